// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: requester IDs and the default
// upper address bits of the sprite attribute table.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SPR  = 2'd1,
    REQ_TILE = 2'd2,
    REQ_CPU  = 2'd3
  } req_id_e;

  localparam logic [8:0] SPRITE_BASE_DEFAULT = 9'h1FC;
  localparam int         SPR_ADDR_W          = 6;
  localparam int         STARVE_W            = 4;

endpackage

// File: rtl/vram_starve_counter.sv
// Saturating up-counter with synchronous clear; tracks consecutive CPU denials.
module vram_starve_counter
  import vram_arbiter_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt
);

  logic [STARVE_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != STARVE_W'(MAX))) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: sprite > tile > CPU, with a one-cycle forced CPU
// slot once the CPU has been denied STARVE_MAX cycles in a row.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int         ADDR_W      = 15,
  parameter int         DATA_W      = 16,
  parameter logic [8:0] SPRITE_BASE = SPRITE_BASE_DEFAULT,
  parameter int         STARVE_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spr_req,
  input  logic [SPR_ADDR_W-1:0] spr_addr,
  input  logic                  tile_req,
  input  logic [ADDR_W-1:0]     tile_addr,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  spr_gnt,
  output logic                  tile_gnt,
  output logic                  cpu_gnt,
  output logic                  cpu_hold,
  output logic                  spr_rvalid,
  output logic                  tile_rvalid,
  output logic                  cpu_rvalid,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  output logic                  ram_we,
  output logic [STARVE_W-1:0]   starve_cnt
);

  req_id_e               owner;
  req_id_e               rd_owner_d, rd_owner_q;
  logic [ADDR_W-1:0]     addr_d, addr_q;
  logic [STARVE_W-1:0]   starve;
  logic                  force_cpu;

  assign force_cpu = cpu_req && (starve == STARVE_W'(STARVE_MAX));

  // Grants are gated by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    owner = REQ_NONE;
    if (reset) begin
      if (force_cpu)     owner = REQ_CPU;
      else if (spr_req)  owner = REQ_SPR;
      else if (tile_req) owner = REQ_TILE;
      else if (cpu_req)  owner = REQ_CPU;
    end
  end

  assign spr_gnt  = (owner == REQ_SPR);
  assign tile_gnt = (owner == REQ_TILE);
  assign cpu_gnt  = (owner == REQ_CPU);
  assign cpu_hold = reset & cpu_req & ~cpu_gnt;
  assign ram_we   = cpu_gnt & cpu_we;
  assign ram_din  = cpu_wdata;

  always_comb begin
    addr_d = addr_q;
    case (owner)
      REQ_SPR:  addr_d = ADDR_W'({SPRITE_BASE, spr_addr});
      REQ_TILE: addr_d = tile_addr;
      REQ_CPU:  addr_d = cpu_addr;
      default:  addr_d = addr_q;
    endcase
    rd_owner_d = ram_we ? REQ_NONE : owner;
  end

  assign ram_addr = addr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      rd_owner_q <= REQ_NONE;
    end else begin
      addr_q     <= addr_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign spr_rvalid  = (rd_owner_q == REQ_SPR);
  assign tile_rvalid = (rd_owner_q == REQ_TILE);
  assign cpu_rvalid  = (rd_owner_q == REQ_CPU);

  vram_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (reset),
    .inc   (cpu_hold),
    .clr   (~cpu_hold),
    .cnt   (starve)
  );

  assign starve_cnt = starve;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic against a request-level reference model and a shadow memory.
module tb_vram_arbiter;

  localparam int         ADDR_W     = 15;
  localparam int         DATA_W     = 16;
  localparam int         STARVE_MAX = 8;
  localparam logic [8:0] SPR_BASE   = 9'h1FC;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              spr_req = 1'b0, tile_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [5:0]        spr_addr = '0;
  logic [ADDR_W-1:0] tile_addr = '0, cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              spr_gnt, tile_gnt, cpu_gnt, cpu_hold;
  logic              spr_rvalid, tile_rvalid, cpu_rvalid, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] ram_dout = '0;

  bit [DATA_W-1:0] ram    [2**ADDR_W];
  bit [DATA_W-1:0] shadow [2**ADDR_W];

  int tests = 0;
  int fails = 0;

  // reference model state
  int                m_starve = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_rv = 0;   // 0 none, 1 sprite, 2 tile, 3 cpu
  logic [DATA_W-1:0] m_rdata = '0;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPRITE_BASE(SPR_BASE), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .spr_req(spr_req), .spr_addr(spr_addr),
    .tile_req(tile_req), .tile_addr(tile_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .spr_gnt(spr_gnt), .tile_gnt(tile_gnt), .cpu_gnt(cpu_gnt), .cpu_hold(cpu_hold),
    .spr_rvalid(spr_rvalid), .tile_rvalid(tile_rvalid), .cpu_rvalid(cpu_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM the arbiter drives
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_grant();
    if (!reset) return 0;
    if (cpu_req && m_starve == STARVE_MAX) return 3;
    if (spr_req) return 1;
    if (tile_req) return 2;
    if (cpu_req) return 3;
    return 0;
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(int g);
    case (g)
      1: return {SPR_BASE, spr_addr};
      2: return tile_addr;
      3: return cpu_addr;
      default: return m_addr;
    endcase
  endfunction

  task automatic model_reset();
    m_starve = 0;
    m_addr   = '0;
    m_rv     = 0;
  endtask

  task automatic drive(input logic s, input logic [5:0] sa, input logic t,
                       input logic [ADDR_W-1:0] ta, input logic c, input logic we,
                       input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] wd);
    spr_req = s; spr_addr = sa; tile_req = t; tile_addr = ta;
    cpu_req = c; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
  endtask

  // advance one clock and update the model with the grant decided this cycle
  task automatic tick();
    int g;
    logic [ADDR_W-1:0] a;
    g = model_grant();
    a = model_addr(g);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      m_rdata = shadow[a];
      if (g == 3 && cpu_we) shadow[a] = cpu_wdata;
      m_rv = (g == 3 && cpu_we) ? 0 : g;
      if (g != 0) m_addr = a;
      if (cpu_req && g != 3) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 6'h11, 1'b1, 15'h0123, 1'b1, 1'b1, 15'h0456, 16'hBEEF);
    #1;
    tests++;
    if ({spr_gnt, tile_gnt, cpu_gnt, ram_we, cpu_hold} !== 5'b0) begin
      fails++;
      $display("FAIL rst_outputs got=%b required=00000", {spr_gnt, tile_gnt, cpu_gnt, ram_we, cpu_hold});
    end
    tests++;
    if ({spr_rvalid, tile_rvalid, cpu_rvalid} !== 3'b0 || starve_cnt !== 4'd0) begin
      fails++;
      $display("FAIL rst_state rvalid=%b starve=%0d required 000/0", {spr_rvalid, tile_rvalid, cpu_rvalid}, starve_cnt);
    end
    tests++;
    if (ram_addr !== 15'h0) begin
      fails++;
      $display("FAIL rst_addr got=%h required=0000", ram_addr);
    end
    tick(); tick();
    tests++;
    if ({spr_gnt, tile_gnt, cpu_gnt} !== 3'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL rst_held_gnt got=%b required=000", {spr_gnt, tile_gnt, cpu_gnt});
    end
    reset = 1'b1;
    #1;
    tests++;
    if (spr_gnt !== 1'b1 || ram_addr !== 15'h7F11) begin
      fails++;
      $display("FAIL rst_first_gnt spr_gnt=%b addr=%h required 1/7f11", spr_gnt, ram_addr);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
  endtask

  task automatic test_priority();
    drive(1'b1, 6'h05, 1'b1, 15'h0100, 1'b1, 1'b0, 15'h0200, 16'h0);
    #1;
    tests++;
    if ({spr_gnt, tile_gnt, cpu_gnt} !== 3'b100 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL prio_gnt got=%b hold=%b required=100/1", {spr_gnt, tile_gnt, cpu_gnt}, cpu_hold);
    end
    tests++;
    if (ram_addr !== 15'h7F05 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL prio_addr got=%h we=%b required=7f05/0", ram_addr, ram_we);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests++;
    if ({spr_rvalid, tile_rvalid, cpu_rvalid} !== 3'b100) begin
      fails++;
      $display("FAIL prio_rvalid got=%b required=100", {spr_rvalid, tile_rvalid, cpu_rvalid});
    end
    tests++;
    if (ram_addr !== 15'h7F05) begin
      fails++;
      $display("FAIL prio_addr_hold got=%h required=7f05", ram_addr);
    end
    tick();
  endtask

  task automatic test_starvation();
    int bad;
    bad = 0;
    drive(1'b0, 6'h0, 1'b1, 15'h0ABC, 1'b1, 1'b0, 15'h0DEF, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      tests++;
      if (cpu_hold !== 1'b1 || tile_gnt !== 1'b1 || cpu_gnt !== 1'b0 || starve_cnt !== 4'(i - 1)) begin
        fails++;
        $display("FAIL starve_hold cyc=%0d hold=%b tile=%b cpu=%b cnt=%0d required 1/1/0/%0d",
                 i, cpu_hold, tile_gnt, cpu_gnt, starve_cnt, i - 1);
      end
      tick();
    end
    #1;
    tests++;
    if (cpu_gnt !== 1'b1 || tile_gnt !== 1'b0 || starve_cnt !== 4'd8 || ram_addr !== 15'h0DEF) begin
      fails++;
      $display("FAIL starve_force cpu=%b tile=%b cnt=%0d addr=%h required 1/0/8/0def",
               cpu_gnt, tile_gnt, starve_cnt, ram_addr);
    end
    tick();
    #1;
    tests++;
    if (tile_gnt !== 1'b1 || cpu_gnt !== 1'b0 || starve_cnt !== 4'd0 || cpu_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL starve_after tile=%b cpu=%b cnt=%0d crv=%b required 1/0/0/1",
               tile_gnt, cpu_gnt, starve_cnt, cpu_rvalid);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
  endtask

  task automatic test_write_read();
    drive(1'b0, 6'h0, 1'b0, 15'h0, 1'b1, 1'b1, 15'h6000, 16'h1234);
    #1;
    tests++;
    if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'h6000 || ram_din !== 16'h1234) begin
      fails++;
      $display("FAIL wr_issue gnt=%b we=%b addr=%h din=%h required 1/1/6000/1234",
               cpu_gnt, ram_we, ram_addr, ram_din);
    end
    tick();
    drive(1'b0, 6'h0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h6000, 16'h0);
    #1;
    tests++;
    if (cpu_rvalid !== 1'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL wr_no_rvalid rvalid=%b we=%b required 0/0", cpu_rvalid, ram_we);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests++;
    if (cpu_rvalid !== 1'b1 || ram_dout !== 16'h1234) begin
      fails++;
      $display("FAIL wr_readback rvalid=%b data=%h required 1/1234", cpu_rvalid, ram_dout);
    end
    tick();
  endtask

  task automatic test_cpu_drop();
    drive(1'b0, 6'h0, 1'b1, 15'h0040, 1'b1, 1'b1, 15'h0050, 16'h5555);
    for (int i = 0; i < 5; i++) tick();
    #1;
    tests++;
    if (starve_cnt !== 4'd5) begin
      fails++;
      $display("FAIL drop_count got=%0d required=5", starve_cnt);
    end
    cpu_req = 1'b0;
    #1;
    tests++;
    if (cpu_gnt !== 1'b0 || cpu_hold !== 1'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL drop_gnt cpu=%b hold=%b we=%b required 0/0/0", cpu_gnt, cpu_hold, ram_we);
    end
    tick();
    #1;
    tests++;
    if (starve_cnt !== 4'd0 || cpu_gnt !== 1'b0) begin
      fails++;
      $display("FAIL drop_clear cnt=%0d cpu=%b required 0/0", starve_cnt, cpu_gnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive(1'b0, 6'h0, 1'b1, 15'h0777, 1'b0, 1'b0, 15'h0, 16'h0);
    tick();
    #1;
    tests++;
    if (tile_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre rvalid=%b required=1", tile_rvalid);
    end
    reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (tile_rvalid !== 1'b0 || tile_gnt !== 1'b0 || ram_addr !== 15'h0) begin
      fails++;
      $display("FAIL rmid_now rvalid=%b gnt=%b addr=%h required 0/0/0000", tile_rvalid, tile_gnt, ram_addr);
    end
    drive(1'b1, 6'h3F, 1'b1, 15'h0777, 1'b1, 1'b1, 15'h0001, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({spr_gnt, tile_gnt, cpu_gnt, ram_we, cpu_hold} !== 5'b0) begin
        fails++;
        $display("FAIL rmid_held cyc=%0d got=%b required=00000", i, {spr_gnt, tile_gnt, cpu_gnt, ram_we, cpu_hold});
      end
    end
    drive(1'b0, 6'h0, 1'b1, 15'h0777, 1'b0, 1'b0, 15'h0, 16'h0);
    reset = 1'b1;
    #1;
    tests++;
    if (tile_gnt !== 1'b1 || tile_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_release gnt=%b rvalid=%b required 1/0", tile_gnt, tile_rvalid);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
  endtask

  task automatic test_random();
    int g;
    logic [ADDR_W-1:0] ea;
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      spr_req   = ($urandom_range(0, 99) < 45);
      spr_addr  = 6'($urandom_range(0, 63));
      tile_req  = ($urandom_range(0, 99) < 45);
      tile_addr = 15'($urandom_range(0, 15));
      cpu_req   = ($urandom_range(0, 99) < 75);
      cpu_we    = ($urandom_range(0, 99) < 40);
      cpu_addr  = 15'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      #1;
      g  = model_grant();
      ea = model_addr(g);
      tests++;
      if ({spr_gnt, tile_gnt, cpu_gnt} !== {g == 1, g == 2, g == 3}) begin
        fails++;
        $display("FAIL rnd_gnt cyc=%0d got=%b required=%b", cyc, {spr_gnt, tile_gnt, cpu_gnt}, {g == 1, g == 2, g == 3});
      end
      tests++;
      if (cpu_hold !== (cpu_req && g != 3) || ram_we !== (g == 3 && cpu_we)) begin
        fails++;
        $display("FAIL rnd_hold_we cyc=%0d hold=%b we=%b required %b/%b",
                 cyc, cpu_hold, ram_we, cpu_req && g != 3, g == 3 && cpu_we);
      end
      tests++;
      if (ram_addr !== ea || ram_din !== cpu_wdata) begin
        fails++;
        $display("FAIL rnd_addr cyc=%0d addr=%h din=%h required %h/%h", cyc, ram_addr, ram_din, ea, cpu_wdata);
      end
      tests++;
      if ({spr_rvalid, tile_rvalid, cpu_rvalid} !== {m_rv == 1, m_rv == 2, m_rv == 3} || starve_cnt !== 4'(m_starve)) begin
        fails++;
        $display("FAIL rnd_state cyc=%0d rvalid=%b cnt=%0d required %b/%0d", cyc,
                 {spr_rvalid, tile_rvalid, cpu_rvalid}, starve_cnt, {m_rv == 1, m_rv == 2, m_rv == 3}, m_starve);
      end
      if (m_rv != 0) begin
        tests++;
        if (ram_dout !== m_rdata) begin
          fails++;
          $display("FAIL rnd_rdata cyc=%0d got=%h required=%h", cyc, ram_dout, m_rdata);
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_starvation();
    test_write_read();
    test_cpu_drop();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
